// File: rtl/frame_tagger.sv
// Frame tagger: stamps each Ethernet frame with a port/sequence ID and a
// round-robin frame-buffer destination, then forwards it as NoC words.
module frame_tagger #(
    parameter int         AVL_DATA_WIDTH     = 512,
    parameter int         FRAME_ID_WIDTH     = 32,
    parameter int         WIDTH_PKT          = AVL_DATA_WIDTH + 1 + 1 + FRAME_ID_WIDTH,
    parameter int         NOC_ADDR_WIDTH     = 4,
    parameter int         FRAME_OFFSET_WIDTH = 5,
    parameter logic [3:0] PORT_ID            = 4'd0,
    parameter int         NUM_DEST           = 4,
    parameter int         DEST_BASE          = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AVL_DATA_WIDTH-1:0] eth_data_in,
    input  logic                      eth_valid_in,
    input  logic                      eth_sop_in,
    input  logic                      eth_eop_in,
    output logic                      eth_ready_out,
    output logic [WIDTH_PKT-1:0]      noc_data_out,
    output logic [NOC_ADDR_WIDTH-1:0] noc_dest_out,
    output logic [3:0]                noc_valid_out,
    output logic [3:0]                noc_sop_out,
    output logic [3:0]                noc_eop_out,
    input  logic                      noc_ready_in,
    output logic [15:0]               err_count
);

    localparam int SEQ_W = FRAME_ID_WIDTH - 4;
    localparam logic [FRAME_OFFSET_WIDTH-1:0] LAST_CNT = FRAME_OFFSET_WIDTH'((1 << FRAME_OFFSET_WIDTH) - 1);
    localparam logic [3:0] RR_LAST = 4'(NUM_DEST - 1);

    typedef enum logic [1:0] {IDLE, IN_FRAME, DROP} state_t;

    state_t                        state, state_next;
    logic [SEQ_W-1:0]              seq;
    logic [3:0]                    rr;
    logic [FRAME_OFFSET_WIDTH-1:0] beat_cnt;
    logic [FRAME_ID_WIDTH-1:0]     cur_id, fwd_id;
    logic [NOC_ADDR_WIDTH-1:0]     cur_dest, fwd_dest, new_dest;
    logic                          accept, fwd, f_sop, f_eop, err_hit, start;

    assign eth_ready_out = (noc_valid_out == 4'b0000) || noc_ready_in;
    assign accept        = eth_valid_in && eth_ready_out;
    assign new_dest      = NOC_ADDR_WIDTH'(DEST_BASE) + NOC_ADDR_WIDTH'(rr);
    assign fwd_id        = (state == IDLE) ? {PORT_ID, seq} : cur_id;
    assign fwd_dest      = (state == IDLE) ? new_dest : cur_dest;

    // Per-beat decision: forward or discard, marker bits, error, next state.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        fwd        = 1'b0;
        f_sop      = 1'b0;
        f_eop      = 1'b0;
        err_hit    = 1'b0;
        start      = 1'b0;
        state_next = state;
        if (accept) begin
            unique case (state)
                IDLE: begin
                    if (eth_sop_in) begin
                        fwd   = 1'b1;
                        f_sop = 1'b1;
                        f_eop = eth_eop_in;
                        start = 1'b1;
                        if (!eth_eop_in) state_next = IN_FRAME;
                    end else begin
                        err_hit = 1'b1;
                        if (!eth_eop_in) state_next = DROP;
                    end
                end
                IN_FRAME: begin
                    fwd = 1'b1;
                    if (eth_sop_in) begin
                        // A new sop truncates the old frame under its own ID.
                        f_eop      = 1'b1;
                        err_hit    = 1'b1;
                        state_next = eth_eop_in ? IDLE : DROP;
                    end else if (beat_cnt == LAST_CNT && !eth_eop_in) begin
                        f_eop      = 1'b1;
                        err_hit    = 1'b1;
                        state_next = DROP;
                    end else begin
                        f_eop = eth_eop_in;
                        if (eth_eop_in) state_next = IDLE;
                    end
                end
                DROP: begin
                    if (eth_eop_in) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            seq           <= '0;
            rr            <= '0;
            beat_cnt      <= '0;
            cur_id        <= '0;
            cur_dest      <= '0;
            err_count     <= '0;
            noc_data_out  <= '0;
            noc_dest_out  <= '0;
            noc_valid_out <= '0;
            noc_sop_out   <= '0;
            noc_eop_out   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= state_next;
            if (start) begin
                cur_id   <= {PORT_ID, seq};
                cur_dest <= new_dest;
                seq      <= seq + 1'b1;
                rr       <= (rr == RR_LAST) ? 4'd0 : rr + 4'd1;
                beat_cnt <= FRAME_OFFSET_WIDTH'(1);
            end else if (fwd) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (err_hit && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (fwd) begin
                noc_data_out  <= {fwd_id, f_sop, f_eop, eth_data_in};
                noc_dest_out  <= fwd_dest;
                noc_valid_out <= 4'b1111;
                noc_sop_out   <= f_sop ? 4'b0001 : 4'b0000;
                noc_eop_out   <= f_eop ? 4'b1000 : 4'b0000;
            end else if (noc_ready_in) begin
                noc_valid_out <= 4'b0000;
                noc_sop_out   <= 4'b0000;
                noc_eop_out   <= 4'b0000;
            end
        end
    end

endmodule
